// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched: issue scheduler and writeback sequencer for the multiply/divide unit.
//
// Requests enter a small in-order queue. The head entry is sent either to the
// single-cycle multiplier (result returned combinationally in the issue cycle)
// or to the multicycle divider (one divide outstanding at most). Both result
// streams are merged onto one registered writeback port. A divider completion
// always wins the writeback slot, and multiplies stall around it so that no
// result is ever dropped.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_ex_i                execute flush: empties queue, abandons divide
//   req_vld_i / req_rdy_o     request handshake (rdy = queue not full)
//   req_op_i                  0-3 MUL/MULH/MULHSU/MULHU, 4-7 DIV/DIVU/REM/REMU
//   req_op1_i, req_op2_i      operands
//   req_tid_i                 transaction id
//   mul_vld_o, mul_op_o,
//   mul_op1_o, mul_op2_o      multiplier issue
//   mul_result_i              multiplier result, same cycle as mul_vld_o
//   div_vld_o / div_rdy_i     divider issue handshake
//   div_op_o, div_op1_o,
//   div_op2_o, div_tid_o      divider issue fields
//   div_done_i, div_tid_i,
//   div_result_i              divider completion (1-cycle pulse)
//   wb_vld_o, wb_tid_o,
//   wb_data_o                 registered writeback
// -----------------------------------------------------------------------------
module md_sched #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_ex_i,

    input  logic                 req_vld_i,
    input  logic [2:0]           req_op_i,
    input  logic [XLEN-1:0]      req_op1_i,
    input  logic [XLEN-1:0]      req_op2_i,
    input  logic [ADDR_BITS-1:0] req_tid_i,
    output logic                 req_rdy_o,

    output logic                 mul_vld_o,
    output logic [2:0]           mul_op_o,
    output logic [XLEN-1:0]      mul_op1_o,
    output logic [XLEN-1:0]      mul_op2_o,
    input  logic [XLEN-1:0]      mul_result_i,

    output logic                 div_vld_o,
    input  logic                 div_rdy_i,
    output logic [2:0]           div_op_o,
    output logic [XLEN-1:0]      div_op1_o,
    output logic [XLEN-1:0]      div_op2_o,
    output logic [ADDR_BITS-1:0] div_tid_o,
    input  logic                 div_done_i,
    input  logic [ADDR_BITS-1:0] div_tid_i,
    input  logic [XLEN-1:0]      div_result_i,

    output logic                 wb_vld_o,
    output logic [ADDR_BITS-1:0] wb_tid_o,
    output logic [XLEN-1:0]      wb_data_o
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        DIdle = 2'd0,
        DBusy = 2'd1,
        DDone = 2'd2
    } div_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]           r_q_op  [QDEPTH];
    logic [XLEN-1:0]      r_q_op1 [QDEPTH];
    logic [XLEN-1:0]      r_q_op2 [QDEPTH];
    logic [ADDR_BITS-1:0] r_q_tid [QDEPTH];

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    div_state_e           r_state;
    div_state_e           w_state_nxt;

    logic [ADDR_BITS-1:0] r_pend_tid;
    logic [XLEN-1:0]      r_pend_data;

    logic                 r_wb_vld;
    logic [ADDR_BITS-1:0] r_wb_tid;
    logic [XLEN-1:0]      r_wb_data;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                 w_full;
    logic                 w_empty;
    logic [2:0]           w_head_op;
    logic [XLEN-1:0]      w_head_op1;
    logic [XLEN-1:0]      w_head_op2;
    logic [ADDR_BITS-1:0] w_head_tid;
    logic                 w_head_is_div;
    logic                 w_wb_reserved;
    logic                 w_div_capture;
    logic                 w_mul_go;
    logic                 w_div_go;
    logic                 w_push;
    logic                 w_pop;

    assign w_full  = (r_count == CNT_W'(QDEPTH));
    assign w_empty = (r_count == '0);

    assign w_head_op     = r_q_op[r_rd_ptr];
    assign w_head_op1    = r_q_op1[r_rd_ptr];
    assign w_head_op2    = r_q_op2[r_rd_ptr];
    assign w_head_tid    = r_q_tid[r_rd_ptr];
    assign w_head_is_div = w_head_op[2];

    // The writeback slot of the next cycle (and the one after a completion)
    // belongs to the divider; a multiply issued now would collide with it.
    assign w_wb_reserved = (r_state == DDone) || ((r_state == DBusy) && div_done_i);

    assign w_div_capture = (r_state == DBusy) && div_done_i && !flush_ex_i;

    assign w_mul_go = !w_empty && !w_head_is_div && !flush_ex_i && !w_wb_reserved;
    assign w_div_go = !w_empty && w_head_is_div && (r_state == DIdle) && div_rdy_i &&
                      !flush_ex_i;

    // Ready is purely !full so it never combinationally depends on dispatch.
    assign req_rdy_o = !w_full;
    assign w_push    = req_vld_i && !w_full && !flush_ex_i;
    assign w_pop     = w_mul_go || w_div_go;

    // ------------------------------------------------------------------
    // Issue outputs
    // ------------------------------------------------------------------
    assign mul_vld_o = w_mul_go;
    assign mul_op_o  = w_head_op;
    assign mul_op1_o = w_head_op1;
    assign mul_op2_o = w_head_op2;

    assign div_vld_o = w_div_go;
    assign div_op_o  = w_head_op;
    assign div_op1_o = w_head_op1;
    assign div_op2_o = w_head_op2;
    assign div_tid_o = w_head_tid;

    // ------------------------------------------------------------------
    // Request queue storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_op[i]  <= '0;
                r_q_op1[i] <= '0;
                r_q_op2[i] <= '0;
                r_q_tid[i] <= '0;
            end
        end else if (w_push) begin
            r_q_op[r_wr_ptr]  <= req_op_i;
            r_q_op1[r_wr_ptr] <= req_op1_i;
            r_q_op2[r_wr_ptr] <= req_op2_i;
            r_q_tid[r_wr_ptr] <= req_tid_i;
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_ex_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divide tracking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= DIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completions seen outside DBusy are stale (e.g. after a flush) and dropped.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_ex_i) begin
            w_state_nxt = DIdle;
        end else begin
            unique case (r_state)
                DIdle:   if (w_div_go) w_state_nxt = DBusy;
                DBusy:   if (div_done_i) w_state_nxt = DDone;
                DDone:   w_state_nxt = DIdle;
                default: w_state_nxt = DIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_tid  <= '0;
            r_pend_data <= '0;
        end else if (flush_ex_i) begin
            r_pend_tid  <= '0;
            r_pend_data <= '0;
        end else if (w_div_capture) begin
            r_pend_tid  <= div_tid_i;
            r_pend_data <= div_result_i;
        end
    end

    // ------------------------------------------------------------------
    // Writeback register: divide result has priority, multiplies were
    // already held off so both never compete for the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_vld  <= 1'b0;
            r_wb_tid  <= '0;
            r_wb_data <= '0;
        end else if (flush_ex_i) begin
            r_wb_vld  <= 1'b0;
        end else if (r_state == DDone) begin
            r_wb_vld  <= 1'b1;
            r_wb_tid  <= r_pend_tid;
            r_wb_data <= r_pend_data;
        end else if (w_mul_go) begin
            r_wb_vld  <= 1'b1;
            r_wb_tid  <= w_head_tid;
            r_wb_data <= mul_result_i;
        end else begin
            r_wb_vld  <= 1'b0;
        end
    end

    assign wb_vld_o  = r_wb_vld;
    assign wb_tid_o  = r_wb_tid;
    assign wb_data_o = r_wb_data;

endmodule

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched: directed self-checking bench for md_sched.
// A scoreboard queue holds expected writebacks in the order they should appear;
// a negedge monitor pops and compares each writeback. Behavioural multiplier
// (combinational) and divider (5-cycle latency, ignores flush so that it
// produces stale completions) models drive the execution-unit inputs.
// -----------------------------------------------------------------------------
module tb_md_sched;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AB   = 3;
    localparam int unsigned QD   = 2;

    logic            clk_i  = 1'b0;
    logic            rst_ni = 1'b1;
    logic            flush_ex_i;
    logic            req_vld_i;
    logic [2:0]      req_op_i;
    logic [XLEN-1:0] req_op1_i;
    logic [XLEN-1:0] req_op2_i;
    logic [AB-1:0]   req_tid_i;
    logic            req_rdy_o;
    logic            mul_vld_o;
    logic [2:0]      mul_op_o;
    logic [XLEN-1:0] mul_op1_o;
    logic [XLEN-1:0] mul_op2_o;
    logic [XLEN-1:0] mul_result_i;
    logic            div_vld_o;
    logic            div_rdy_i;
    logic [2:0]      div_op_o;
    logic [XLEN-1:0] div_op1_o;
    logic [XLEN-1:0] div_op2_o;
    logic [AB-1:0]   div_tid_o;
    logic            div_done_i;
    logic [AB-1:0]   div_tid_i;
    logic [XLEN-1:0] div_result_i;
    logic            wb_vld_o;
    logic [AB-1:0]   wb_tid_o;
    logic [XLEN-1:0] wb_data_o;

    typedef struct packed {
        logic [AB-1:0]   tid;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t sb[$];
    wb_t mon_exp;
    int  n_tests    = 0;
    int  n_fail     = 0;
    int  div_pulses = 0;

    md_sched #(
        .XLEN      (XLEN),
        .ADDR_BITS (AB),
        .QDEPTH    (QD)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_ex_i   (flush_ex_i),
        .req_vld_i    (req_vld_i),
        .req_op_i     (req_op_i),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .req_tid_i    (req_tid_i),
        .req_rdy_o    (req_rdy_o),
        .mul_vld_o    (mul_vld_o),
        .mul_op_o     (mul_op_o),
        .mul_op1_o    (mul_op1_o),
        .mul_op2_o    (mul_op2_o),
        .mul_result_i (mul_result_i),
        .div_vld_o    (div_vld_o),
        .div_rdy_i    (div_rdy_i),
        .div_op_o     (div_op_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_tid_o    (div_tid_o),
        .div_done_i   (div_done_i),
        .div_tid_i    (div_tid_i),
        .div_result_i (div_result_i),
        .wb_vld_o     (wb_vld_o),
        .wb_tid_o     (wb_tid_o),
        .wb_data_o    (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference arithmetic for the execution-unit models.
    function automatic logic [XLEN-1:0] ref_calc(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [63:0] sa;
        logic [63:0] ua;
        logic [63:0] sbv;
        logic [63:0] ubv;
        logic [63:0] p;
        sa  = {{32{a[31]}}, a};
        ua  = {32'h0, a};
        sbv = {{32{b[31]}}, b};
        ubv = {32'h0, b};
        case (op)
            3'd0: begin p = sa * sbv; return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ubv; return p[63:32]; end
            3'd3: begin p = ua * ubv; return p[63:32]; end
            3'd4: return $signed(a) / $signed(b);
            3'd5: return a / b;
            3'd6: return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    assign mul_result_i = ref_calc(mul_op_o, mul_op1_o, mul_op2_o);

    // Divider model: completes 5 cycles after the issue cycle.
    int            dm_cnt  = 0;
    logic          dm_done = 1'b0;
    logic [AB-1:0] dm_tid  = '0;
    logic [XLEN-1:0] dm_res = '0;

    assign div_done_i   = dm_done;
    assign div_tid_i    = dm_tid;
    assign div_result_i = dm_res;

    always begin
        @(negedge clk_i);
        if (div_vld_o && div_rdy_i) begin
            dm_cnt = 5;
            dm_tid = div_tid_o;
            dm_res = ref_calc(div_op_o, div_op1_o, div_op2_o);
        end
        @(posedge clk_i);
        #1;
        dm_done = 1'b0;
        if (dm_cnt != 0) begin
            dm_cnt = dm_cnt - 1;
            if (dm_cnt == 0) dm_done = 1'b1;
        end
    end

    // Writeback monitor / scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && div_vld_o && div_rdy_i) div_pulses++;
        if (rst_ni && wb_vld_o) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL wb_unexpected: observed tid %0d data %0h, required no writeback",
                       wb_tid_o, wb_data_o);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                n_tests++;
                assert (wb_tid_o === mon_exp.tid) else begin
                    n_fail++;
                    $error("FAIL wb_tid: observed %0d required %0d", wb_tid_o, mon_exp.tid);
                end
                n_tests++;
                assert (wb_data_o === mon_exp.data) else begin
                    n_fail++;
                    $error("FAIL wb_data: observed %0h required %0h", wb_data_o, mon_exp.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [AB-1:0] tid);
        req_op_i  = op;
        req_op1_i = a;
        req_op2_i = b;
        req_tid_i = tid;
        req_vld_i = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [AB-1:0] tid,
                        input logic [XLEN-1:0] exp);
        wb_t e;
        drive(op, a, b, tid);
        e.tid  = tid;
        e.data = exp;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(sb.size()), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_rdy"}, req_rdy_o, 1);
        chk({tag, "_wb_vld"},  wb_vld_o,  0);
        chk({tag, "_wb_tid"},  wb_tid_o,  0);
        chk({tag, "_wb_data"}, wb_data_o, 0);
        chk({tag, "_mul_vld"}, mul_vld_o, 0);
        chk({tag, "_div_vld"}, div_vld_o, 0);
    endtask

    initial begin
        int n;
        int p0;
        flush_ex_i = 1'b0;
        req_vld_i  = 1'b0;
        req_op_i   = '0;
        req_op1_i  = '0;
        req_op2_i  = '0;
        req_tid_i  = '0;
        div_rdy_i  = 1'b1;

        // Reset values
        #1 rst_ni = 1'b0;
        #2;
        chk_reset("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single MUL: accepted c0, issued c1, written back c2
        send(3'd0, 32'd6, 32'd7, 3'd2, 32'd42);
        settle();
        chk("t1_mul_vld_c0", mul_vld_o, 0);
        tick(); req_vld_i = 1'b0; settle();
        chk("t1_mul_vld_c1", mul_vld_o, 1);
        chk("t1_mul_op1", mul_op1_o, 6);
        chk("t1_wb_vld_c1", wb_vld_o, 0);
        tick(); settle();
        chk("t1_wb_vld_c2", wb_vld_o, 1);
        chk("t1_wb_tid", wb_tid_o, 2);
        chk("t1_wb_data", wb_data_o, 42);
        tick(); settle();
        chk("t1_wb_vld_drop", wb_vld_o, 0);
        chk("t1_wb_data_hold", wb_data_o, 42);

        // DIV 100/7: issue c1, done c6, pending written back during c7 -> visible c8
        p0 = div_pulses;
        send(3'd4, 32'd100, 32'd7, 3'd1, 32'd14);
        tick(); req_vld_i = 1'b0; settle();
        chk("t2_div_vld", div_vld_o, 1);
        chk("t2_div_tid", div_tid_o, 1);
        chk("t2_div_op1", div_op1_o, 100);
        n = 0;
        do begin
            tick(); settle(); n++;
        end while (!wb_vld_o && n < 20);
        chk("t2_wb_latency", 64'(n), 7);
        chk("t2_wb_tid", wb_tid_o, 1);
        chk("t2_wb_data", wb_data_o, 14);
        tick(); settle();
        chk("t2_div_pulses", 64'(div_pulses - p0), 1);

        // Collision: MUL reaches the head in the div_done cycle (c6)
        send(3'd4, 32'd100, 32'd7, 3'd1, 32'd14);
        tick(); req_vld_i = 1'b0; settle();
        chk("t3_div_vld", div_vld_o, 1);
        tick(); tick(); tick(); tick();
        send(3'd0, 32'd3, 32'd5, 3'd3, 32'd15);
        tick(); req_vld_i = 1'b0; settle();
        chk("t3_mul_stall_c6", mul_vld_o, 0);
        tick(); settle();
        chk("t3_mul_stall_c7", mul_vld_o, 0);
        tick(); settle();
        chk("t3_mul_go_c8", mul_vld_o, 1);
        chk("t3_wb_div_vld", wb_vld_o, 1);
        chk("t3_wb_div_tid", wb_tid_o, 1);
        tick(); settle();
        chk("t3_wb_mul_vld", wb_vld_o, 1);
        chk("t3_wb_mul_tid", wb_tid_o, 3);
        chk("t3_wb_mul_data", wb_data_o, 15);
        tick();

        // Back-to-back DIVs with the queue filled while the divider is not ready
        p0 = div_pulses;
        div_rdy_i = 1'b0;
        send(3'd7, 32'd100, 32'd7, 3'd1, 32'd2);
        tick();
        send(3'd6, 32'hFFFF_FFEC, 32'd6, 3'd2, 32'hFFFF_FFFE);
        settle();
        chk("t4_div_blocked", div_vld_o, 0);
        chk("t4_rdy_one", req_rdy_o, 1);
        tick();
        drive(3'd0, 32'd9, 32'd9, 3'd5);  // offered while full: must be dropped
        settle();
        chk("t4_rdy_full", req_rdy_o, 0);
        tick(); req_vld_i = 1'b0; div_rdy_i = 1'b1; settle();
        chk("t4_div1_vld", div_vld_o, 1);
        chk("t4_div1_tid", div_tid_o, 1);
        chk("t4_rdy_no_bypass", req_rdy_o, 0);
        tick(); settle();
        chk("t4_rdy_after_pop", req_rdy_o, 1);
        repeat (5) tick();
        settle();
        chk("t4_div2_wait", div_vld_o, 0);
        tick(); settle();
        chk("t4_div2_vld", div_vld_o, 1);
        chk("t4_div2_tid", div_tid_o, 2);
        chk("t4_wb1_vld", wb_vld_o, 1);
        chk("t4_wb1_tid", wb_tid_o, 1);
        chk("t4_pulses_before", 64'(div_pulses - p0), 1);
        wait_idle("t4_drain");

        // Flush with a DIV in flight and two queued requests
        send(3'd4, 32'd50, 32'd5, 3'd1, 32'd10);
        tick();
        send(3'd4, 32'd8, 32'd2, 3'd2, 32'd4);
        tick();
        send(3'd0, 32'd2, 32'd2, 3'd3, 32'd4);
        tick();
        req_vld_i = 1'b0; flush_ex_i = 1'b1;
        sb.delete();
        settle();
        chk("t5_full_at_flush", req_rdy_o, 0);
        chk("t5_flush_no_mul", mul_vld_o, 0);
        chk("t5_flush_no_div", div_vld_o, 0);
        tick(); flush_ex_i = 1'b0; settle();
        chk("t5_rdy_after", req_rdy_o, 1);
        chk("t5_wb_vld_after", wb_vld_o, 0);
        chk("t5_mul_after", mul_vld_o, 0);
        chk("t5_div_after", div_vld_o, 0);
        tick();
        flush_ex_i = 1'b1;
        drive(3'd0, 32'd1, 32'd1, 3'd6);  // enqueue must be suppressed by flush
        tick(); flush_ex_i = 1'b0; req_vld_i = 1'b0; settle();
        chk("t5_no_enq_in_flush", mul_vld_o, 0);
        repeat (6) tick();  // stale divider completion lands in this window
        chk("t5_stale_ignored", 64'(sb.size()), 0);

        // Mixed MUL variants issued back-to-back
        send(3'd1, 32'hFFFF_FFFD, 32'd5, 3'd0, 32'hFFFF_FFFF);
        tick();
        send(3'd2, 32'hFFFF_FFFF, 32'd2, 3'd6, 32'hFFFF_FFFF);
        tick();
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 32'hFFFF_FFFE);
        tick();
        send(3'd0, 32'd12345, 32'd1000, 3'd4, 32'd12345000);
        tick(); req_vld_i = 1'b0;
        wait_idle("t6_drain");

        // Asynchronous reset in the middle of a divide
        send(3'd5, 32'd1000, 32'd10, 3'd4, 32'd100);
        tick(); req_vld_i = 1'b0; settle();
        chk("t7_div_vld", div_vld_o, 1);
        tick(); tick();
        #2 rst_ni = 1'b0;
        #1;
        chk_reset("t7_rst");
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        send(3'd3, 32'hFFFF_FFFF, 32'd2, 3'd5, 32'd1);
        tick(); req_vld_i = 1'b0; settle();
        chk("t7_mul_vld", mul_vld_o, 1);
        tick(); settle();
        chk("t7_wb_vld", wb_vld_o, 1);
        chk("t7_wb_tid", wb_tid_o, 5);
        chk("t7_wb_data", wb_data_o, 1);
        repeat (6) tick();
        chk("t7_sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary, required completion");
        $fatal(1, "timeout");
    end

endmodule
